// File: rtl/mem_bus_arbiter_if.sv
// Native valid/ready memory bus (picorv32 style) bundled as an interface.
// A master drives the request fields and receives rdata/ready; a slave does the reverse.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  valid;
  logic                  instr;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic [DATA_W-1:0]     rdata;
  logic                  ready;

  modport master (output valid, instr, addr, wdata, wstrb, input rdata, ready);
  modport slave  (input valid, instr, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the native valid/ready memory bus.
// M0 is the CPU core, M1 a secondary master (DMA / debug loader); the single
// slave port feeds the system address decoder. One whole transaction is owned
// by one master from valid to ready, followed by a one-cycle DONE gap so a
// master's stale valid is never granted a second time.
// Optional feature: define BUS_TIMEOUT_EN to abort transactions the slave never
// completes (adds the TIMEOUT_CYCLES parameter and the timeout_err port).
module mem_bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int ROUND_ROBIN    = 1
`ifdef BUS_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              clk,
  input  logic              reset,
  mem_bus_arbiter_if.slave  m0,
  mem_bus_arbiter_if.slave  m1,
  mem_bus_arbiter_if.master s,
  output logic [1:0]        grant
`ifdef BUS_TIMEOUT_EN
  , output logic            timeout_err
`endif
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, DONE} state_t;

  state_t state_q, state_d;
  // last_q = 1 means M1 was served most recently, so M0 wins the next tie
  logic   last_q, last_d;

  logic                gnt1;
  logic                own_valid;
  logic                own_instr;
  logic [ADDR_W-1:0]   own_addr;
  logic [DATA_W-1:0]   own_wdata;
  logic [DATA_W/8-1:0] own_wstrb;
  logic                ready_w;
  logic [DATA_W-1:0]   rdata_w;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // State and last-served registers; reset abandons any transaction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  // Stall counter: zero outside a grant, counts granted cycles lacking s_ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

  // Arbitration, owner muxing and transaction completion
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant     = 2'b00;
    gnt1      = (state_q == GNT1);
    own_valid = 1'b0;
    own_instr = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    own_wstrb = '0;
    ready_w   = 1'b0;
    rdata_w   = '0;
    s.valid   = 1'b0;
    s.instr   = 1'b0;
    s.addr    = '0;
    s.wdata   = '0;
    s.wstrb   = '0;
    m0.ready  = 1'b0;
    m0.rdata  = '0;
    m1.ready  = 1'b0;
    m1.rdata  = '0;
`ifdef BUS_TIMEOUT_EN
    timeout_err = 1'b0;
    cnt_d       = '0;
`endif
    case (state_q)
      IDLE: begin
        if (m0.valid && m1.valid)
          state_d = ((ROUND_ROBIN != 0) && !last_q) ? GNT1 : GNT0;
        else if (m0.valid)
          state_d = GNT0;
        else if (m1.valid)
          state_d = GNT1;
      end
      GNT0, GNT1: begin
        grant     = gnt1 ? 2'b10 : 2'b01;
        own_valid = gnt1 ? m1.valid : m0.valid;
        own_instr = gnt1 ? m1.instr : m0.instr;
        own_addr  = gnt1 ? m1.addr  : m0.addr;
        own_wdata = gnt1 ? m1.wdata : m0.wdata;
        own_wstrb = gnt1 ? m1.wstrb : m0.wstrb;
        s.valid   = own_valid;
        s.instr   = own_instr;
        s.addr    = own_addr;
        s.wdata   = own_wdata;
        s.wstrb   = own_wstrb;
        rdata_w   = s.rdata;
        ready_w   = own_valid && s.ready;
        if (!own_valid) begin
          state_d = IDLE;
        end else if (s.ready) begin
          state_d = DONE;
          last_d  = gnt1;
`ifdef BUS_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          s.valid     = 1'b0;
          ready_w     = 1'b1;
          rdata_w     = '1;
          timeout_err = 1'b1;
          state_d     = DONE;
          last_d      = gnt1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
        if (gnt1) begin
          m1.ready = ready_w;
          m1.rdata = rdata_w;
        end else begin
          m0.ready = ready_w;
          m0.rdata = rdata_w;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule
